// File: rtl/imu_link_controller.sv
// rtl/imu_link_controller.sv - IMU packet link-state sequencer with one-deep sample handshake
// Optional IMU_LINK_STATS_EN adds good-packet and drop counters.
module imu_link_controller #(
    parameter int TIMEOUT_CYCLES = 1200000,
    parameter int LOCK_COUNT     = 4,
    parameter int ERR_LIMIT      = 8,
    parameter int TMR_W          = 21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pkt_strobe,
    input  logic        pkt_hdr_ok,
    input  logic [1:0]  pkt_flags,
    input  logic        clear_fault,
    input  logic        sample_ready,
    output logic        sample_valid,
    output logic [1:0]  sample_flags,
    output logic        overrun,
    output logic [2:0]  link_state,
    output logic        link_up,
    output logic        stale,
    output logic        fault,
`ifdef IMU_LINK_STATS_EN
    output logic [15:0] pkt_count,
    output logic [15:0] drop_count,
`endif
    output logic [3:0]  err_count
);
    typedef enum logic [2:0] {
        ST_DOWN = 3'd0, ST_ACQ = 3'd1, ST_LOCKED = 3'd2, ST_HOLD = 3'd3, ST_FAULT = 3'd4
    } state_t;

    localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [TMR_W-1:0] TMO_MAX  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]    LOCK_N   = GW'(LOCK_COUNT);
    localparam logic [3:0]       ERR_MAX  = 4'(ERR_LIMIT);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [GW-1:0]    good_cnt_q, good_cnt_d;
    logic [3:0]       err_q, err_d;
    logic             valid_q, valid_d;
    logic [1:0]       flags_q, flags_d;
    logic             overrun_q, overrun_d;
    logic             link_up_q, stale_q, fault_q;
    logic             good, bad, timeout, issue, hs;

    always_comb begin
        // Packets are invisible while faulted; only clear_fault acts there.
        good       = pkt_strobe & pkt_hdr_ok & (state_q != ST_FAULT);
        bad        = pkt_strobe & ~pkt_hdr_ok & (state_q != ST_FAULT);
        timeout    = (timer_q == TMO_LAST) & ~good;
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        err_d      = err_q;
        issue      = 1'b0;
        case (state_q)
            ST_DOWN: begin
                if (good) begin
                    good_cnt_d = GW'(1);
                    state_d    = (LOCK_COUNT == 1) ? ST_LOCKED : ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (good) begin
                    good_cnt_d = good_cnt_q + GW'(1);
                    if (good_cnt_q + GW'(1) == LOCK_N) state_d = ST_LOCKED;
                end else if (bad || timeout) begin
                    state_d = ST_DOWN;
                end
            end
            ST_LOCKED, ST_HOLD: begin
                if (good) begin
                    issue   = 1'b1;
                    err_d   = 4'd0;
                    state_d = ST_LOCKED;
                end else begin
                    if (bad) err_d = err_q + 4'd1;
                    if (bad && (err_q + 4'd1 == ERR_MAX)) state_d = ST_FAULT;
                    else if (timeout) state_d = (state_q == ST_LOCKED) ? ST_HOLD : ST_DOWN;
                end
            end
            ST_FAULT: begin
                if (clear_fault) state_d = ST_DOWN;
            end
            default: state_d = ST_DOWN;
        endcase
        if (state_d == ST_DOWN) begin
            good_cnt_d = '0;
            err_d      = 4'd0;
        end

        if (good || (state_d != state_q)) timer_d = '0;
        else if (timer_q == TMO_MAX)      timer_d = timer_q;
        else                              timer_d = timer_q + TMR_W'(1);

        hs        = valid_q & sample_ready;
        valid_d   = issue | (valid_q & ~hs);
        flags_d   = issue ? pkt_flags : flags_q;
        overrun_d = issue & valid_q & ~hs;
        if (state_d == ST_DOWN || state_d == ST_FAULT) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_DOWN;
            timer_q    <= '0;
            good_cnt_q <= '0;
            err_q      <= 4'd0;
            valid_q    <= 1'b0;
            flags_q    <= 2'b00;
            overrun_q  <= 1'b0;
            link_up_q  <= 1'b0;
            stale_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            good_cnt_q <= good_cnt_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            flags_q    <= flags_d;
            overrun_q  <= overrun_d;
            link_up_q  <= (state_d == ST_LOCKED);
            stale_q    <= (state_d == ST_HOLD);
            fault_q    <= (state_d == ST_FAULT);
        end
    end

`ifdef IMU_LINK_STATS_EN
    logic [15:0] pkt_q, drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q  <= 16'd0;
            drop_q <= 16'd0;
        end else if (state_q == ST_FAULT && clear_fault) begin
            pkt_q  <= 16'd0;
            drop_q <= 16'd0;
        end else begin
            if (good) pkt_q <= pkt_q + 16'd1;
            if ((overrun_d || (bad && state_q != ST_DOWN)) && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;
        end
    end

    assign pkt_count  = pkt_q;
    assign drop_count = drop_q;
`endif

    assign link_state   = state_q;
    assign link_up      = link_up_q;
    assign stale        = stale_q;
    assign fault        = fault_q;
    assign err_count    = err_q;
    assign sample_valid = valid_q;
    assign sample_flags = flags_q;
    assign overrun      = overrun_q;
endmodule

// File: doc/imu_link_controller.md
Name: imu_link_controller

Overview:
- Sequences the IMU sensor stream behind the Arduino SPI slave receiver.
- Qualifies incoming packets, runs a link-state machine (acquire, lock, holdover, fault) and supervises packet timeouts.
- Presents each accepted packet to the downstream consumer through a one-deep valid/ready sample handshake.
- Sits between the SPI receiver's packet-complete strobe and the orientation/gesture logic in the clk domain.

Parameters:
- TIMEOUT_CYCLES, 1200000: clk cycles without a good packet before timeout (25 ms at 48 MHz).
- LOCK_COUNT, 4: consecutive good packets required to reach LOCKED. Legal range is 1 or more.
- ERR_LIMIT, 8: consecutive bad packets in LOCKED/HOLD that force FAULT. Legal range is 1 to 15.
- TMR_W, 21: timer width. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  FPGA system clock
- rst_n  in  1  asynchronous active-low reset
- pkt_strobe  in  1  one-cycle pulse: packet snapshot captured (CS rising edge)
- pkt_hdr_ok  in  1  header byte == 0xAA; qualified by pkt_strobe
- pkt_flags  in  2  {gyro_valid, euler_valid} from packet byte 13; qualified by pkt_strobe
- clear_fault  in  1  one-cycle pulse: leave FAULT
- sample_ready  in  1  consumer accepts sample
- sample_valid  out  1  sample pending
- sample_flags  out  2  pkt_flags of the pending sample
- overrun  out  1  one-cycle pulse: pending sample overwritten
- link_state  out  3  DOWN=0, ACQ=1, LOCKED=2, HOLD=3, FAULT=4
- link_up  out  1  link_state==LOCKED
- stale  out  1  link_state==HOLD
- fault  out  1  link_state==FAULT
- err_count  out  4  consecutive bad packets, saturating at ERR_LIMIT

Behaviour:
- Reset: state DOWN. All outputs 0. Timer, good_cnt and err_count are 0.
- Event definitions:
  - good = pkt_strobe & pkt_hdr_ok
  - bad = pkt_strobe & !pkt_hdr_ok
- All outputs are registered. Event at cycle N is visible at N+1.
- Timer:
  - Clears on good and on every state change.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - timeout = (timer == TIMEOUT_CYCLES-1) & !good.
  - Timer counting is not paused in FAULT, but timeout has no effect there.
- DOWN:
  - good -> ACQ with good_cnt=1; goes directly to LOCKED if LOCK_COUNT==1.
  - bad is ignored.
- ACQ:
  - good -> good_cnt+1; on reaching LOCK_COUNT -> LOCKED.
  - bad or timeout -> DOWN, good_cnt=0.
  - No samples are issued in ACQ.
- LOCKED:
  - good -> issue sample, err_count=0.
  - bad -> err_count+1; if it reaches ERR_LIMIT -> FAULT.
  - timeout -> HOLD.
- HOLD:
  - good -> LOCKED and issue sample, err_count=0.
  - bad -> same err_count rule as LOCKED.
  - Second timeout -> DOWN.
- FAULT:
  - pkt_strobe is ignored.
  - clear_fault -> DOWN; err_count, good_cnt and sample_valid are cleared.
  - clear_fault in any other state is ignored.
- Issuing a sample:
  - sample_flags <= pkt_flags; sample_valid <= 1.
  - If sample_valid was 1 and not handshaken that cycle, overrun pulses 1 at N+1.
  - If ready and a new sample coincide, the old sample is consumed, the new one is loaded, and there is no overrun.
- Handshake:
  - sample_valid & sample_ready clears sample_valid next cycle, unless a new sample is issued.
  - sample_valid holds until accepted.
- Leaving the link:
  - Entering DOWN or FAULT clears sample_valid without overrun.
  - HOLD preserves a pending sample.
- Simultaneous events:
  - good beats timeout.
  - clear_fault with pkt_strobe in FAULT: go to DOWN; the packet is not counted.
- Reset mid-operation: immediate asynchronous return to the reset values above.

Optional Feature:
- Macro IMU_LINK_STATS_EN.
- When defined, adds:
  - output pkt_count[15:0]: wrapping count of good packets in any non-FAULT state.
  - output drop_count[15:0]: saturating at 0xFFFF; increments on each overrun pulse and on each bad packet outside DOWN/FAULT.
- Both counters reset to 0 and are cleared by clear_fault.
- When not defined, these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Bench uses TIMEOUT_CYCLES=100, LOCK_COUNT=4, ERR_LIMIT=3.
- Acquire: 4 good strobes, flags=2'b11, 20 cycles apart -> link_state 1,1,1,2; link_up=1 one cycle after the 4th; sample_valid=1 only after entering LOCKED, on the next good.
- Handshake/overrun: in LOCKED, 2 good strobes (flags 01, then 10) with sample_ready=0 -> overrun pulses once, sample_flags=10; ready=1 for one cycle -> sample_valid=0.
- Timeout/holdover: in LOCKED, no strobe for 100 cycles -> HOLD, stale=1, pending sample kept; good at cycle 50 -> LOCKED; otherwise 100 more cycles -> DOWN, sample_valid=0.
- Fault: in LOCKED, 3 strobes with hdr_ok=0 -> err_count 1,2,3, state FAULT; further good strobes are ignored; clear_fault -> DOWN, err_count=0.
- Error recovery: bad, bad, good in LOCKED -> err_count 1,2,0; state stays LOCKED. Bad in ACQ -> DOWN.
- Reset: assert rst_n=0 mid-ACQ with sample pending -> all outputs 0 immediately, without waiting for a clk edge.
